// File: rtl/barrier_irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// barrier_irq_ctrl_pkg
//
// Shared definitions for the shader-core completion interrupt controller:
//   - CAUSE_* : 2-bit encodings reported on irq_cause
//   - state_e : controller state (collecting dones / interrupt outstanding)
//   - CORE_NUM_MAX and core_num_ok() : legal range for the core count
// ---------------------------------------------------------------------------
package barrier_irq_ctrl_pkg;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_BARRIER = 2'b01;
   localparam logic [1:0] CAUSE_ANY     = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

   localparam int CORE_NUM_MAX = 32;

   // COLLECT gathers done pulses for the current round; FIRED holds the
   // interrupt until the host (or the pulse auto-rearm) releases it.
   typedef enum logic {
      COLLECT = 1'b0,
      FIRED   = 1'b1
   } state_e;

   // The done/enable vectors are at most one 32-bit word wide on the host side.
   function automatic bit core_num_ok(input int n);
      return (n >= 1) && (n <= CORE_NUM_MAX);
   endfunction

endpackage

// File: rtl/barrier_irq_ctrl_stall.sv
// ---------------------------------------------------------------------------
// stall_timer
//
// Saturating stall counter used to detect a barrier that never completes.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   en       in   count this cycle
//   clr      in   return the count to zero (wins over en)
//   limit    in   stall limit in cycles; 0 means the timer never expires
//   expired  out  the current cycle is the last one of the stall window
// ---------------------------------------------------------------------------
module stall_timer #(
   parameter int TIMEOUT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 clr,
   input  logic [TIMEOUT_W-1:0] limit,
   output logic                 expired
);

   localparam logic [TIMEOUT_W-1:0] ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

   logic [TIMEOUT_W-1:0] count_q;
   logic [TIMEOUT_W-1:0] count_d;

   // Next count: clear has priority; otherwise count up while enabled and
   // stick at all-ones so a long stall never wraps back into the window.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != '1)) begin
         count_d = count_q + ONE;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // The count equals the number of stalled cycles already elapsed, so the
   // window ends on the cycle where it reaches limit-1.
   assign expired = (limit != '0) && (count_q == (limit - ONE));

endmodule

// File: rtl/barrier_irq_ctrl.sv
// ---------------------------------------------------------------------------
// barrier_irq_ctrl
//
// Collects per-core done pulses from CORE_NUM shader cores and raises one
// host interrupt when every enabled core has finished (barrier mode), when
// any enabled core has finished (any mode), or when a barrier stalls past a
// programmable timeout. The interrupt is either held until irq_ack or sent
// as a one-cycle pulse (PULSE_MODE=1), and reports cause and core status.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   core_done      in   per-core done, any pulse width
//   core_en        in   per-core enable
//   mode           in   0 = barrier, 1 = any
//   timeout_limit  in   stall limit in cycles, 0 disables the timeout
//   irq_ack        in   host acknowledge (ignored when PULSE_MODE=1)
//   irq            out  interrupt to host
//   irq_cause      out  CAUSE_* of the last fire, CAUSE_NONE once released
//   done_status    out  enabled cores that were done at fire time
//   missing        out  enabled cores that were not done at fire time
//   busy           out  round in progress (an enabled core has reported)
// ---------------------------------------------------------------------------
module barrier_irq_ctrl
   import barrier_irq_ctrl_pkg::*;
#(
   parameter int CORE_NUM   = 4,
   parameter int TIMEOUT_W  = 16,
   parameter int PULSE_MODE = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CORE_NUM-1:0]  core_done,
   input  logic [CORE_NUM-1:0]  core_en,
   input  logic                 mode,
   input  logic [TIMEOUT_W-1:0] timeout_limit,
   input  logic                 irq_ack,
   output logic                 irq,
   output logic [1:0]           irq_cause,
   output logic [CORE_NUM-1:0]  done_status,
   output logic [CORE_NUM-1:0]  missing,
   output logic                 busy
);

   generate
      if (!core_num_ok(CORE_NUM)) begin : g_core_num_bad
         $error("barrier_irq_ctrl: CORE_NUM must be in 1..32");
      end
   endgenerate

   state_e              state_q, state_d;
   logic [CORE_NUM-1:0] done_q, done_d;
   logic [CORE_NUM-1:0] pend_q, pend_d;
   logic                irq_q, irq_d;
   logic [1:0]          cause_q, cause_d;
   logic [CORE_NUM-1:0] status_q, status_d;
   logic [CORE_NUM-1:0] missing_q, missing_d;

   logic [CORE_NUM-1:0] eff;
   logic                en_any;
   logic                barrier_done;
   logic                any_done;
   logic                stall_active;
   logic                timer_expired;
   logic                timeout_hit;
   logic                release_irq;
   logic                fire;
   logic                timer_clr;

   // Round evaluation. A done arriving this cycle counts immediately so the
   // interrupt follows one edge after the last done. Disabled cores count as
   // finished for the barrier and are ignored by any mode; completion is
   // re-checked against the live enable mask every cycle.
   always_comb begin
      eff          = done_q | core_done;
      en_any       = |core_en;
      barrier_done = !mode && en_any && (&(eff | ~core_en));
      any_done     = mode && (|(eff & core_en));
      stall_active = (state_q == COLLECT) && !mode && (|(eff & core_en)) &&
                     (timeout_limit != '0);
      timeout_hit  = stall_active && timer_expired && !barrier_done;
      release_irq  = (PULSE_MODE != 0) ? 1'b1 : irq_ack;
   end

   // Stall window opens on the cycle the first enabled done arrives and
   // closes whenever the round fires, is released or goes idle again.
   stall_timer #(
      .TIMEOUT_W (TIMEOUT_W)
   ) u_stall_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (stall_active),
      .clr     (timer_clr),
      .limit   (timeout_limit),
      .expired (timer_expired)
   );

   // Next-state logic. In COLLECT we either fire (capturing status and
   // clearing the round) or keep accumulating dones. In FIRED the outputs
   // stay frozen and new dones are parked in pend_q; the release (host ack,
   // or automatically after one cycle in pulse mode) seeds the next round
   // with everything that arrived meanwhile, including this cycle's dones.
   always_comb begin
      state_d   = state_q;
      done_d    = done_q;
      pend_d    = pend_q;
      irq_d     = irq_q;
      cause_d   = cause_q;
      status_d  = status_q;
      missing_d = missing_q;
      fire      = 1'b0;

      unique case (state_q)
         COLLECT: begin
            if (barrier_done || any_done || timeout_hit) begin
               fire      = 1'b1;
               state_d   = FIRED;
               irq_d     = 1'b1;
               status_d  = eff & core_en;
               missing_d = core_en & ~eff;
               done_d    = '0;
               if (barrier_done) begin
                  cause_d = CAUSE_BARRIER;
               end else if (any_done) begin
                  cause_d = CAUSE_ANY;
               end else begin
                  cause_d = CAUSE_TIMEOUT;
               end
            end else begin
               done_d = eff;
            end
         end
         FIRED: begin
            if (release_irq) begin
               state_d = COLLECT;
               irq_d   = 1'b0;
               cause_d = CAUSE_NONE;
               done_d  = pend_q | core_done;
               pend_d  = '0;
            end else begin
               pend_d = pend_q | core_done;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase

      timer_clr = fire || !stall_active;
   end

   // State and output registers; reset discards any pending dones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= COLLECT;
         done_q    <= '0;
         pend_q    <= '0;
         irq_q     <= 1'b0;
         cause_q   <= CAUSE_NONE;
         status_q  <= '0;
         missing_q <= '0;
      end else begin
         state_q   <= state_d;
         done_q    <= done_d;
         pend_q    <= pend_d;
         irq_q     <= irq_d;
         cause_q   <= cause_d;
         status_q  <= status_d;
         missing_q <= missing_d;
      end
   end

   assign irq         = irq_q;
   assign irq_cause   = cause_q;
   assign done_status = status_q;
   assign missing     = missing_q;
   assign busy        = (state_q == COLLECT) && (|(done_q & core_en));

endmodule
